vga_framebuffer: RTL and testbench
==================================

// Module: vga_framebuffer
// PURPOSE
//  Consumer of the VGA timing generator: takes its pixel position, sync and blank, and produces aligned RGB + sync for the pins.
//  Holds a coarse cell framebuffer: 80x60 cells at default SCALE_SHIFT=3, i.e. 8x8 screen pixels per cell.
//  Write port (valid/ready) fed by the MCU/SPI command decoder; clear-screen engine fills every cell with BG_COLOR.
// PARAMETERS
//  HACTIVE      640   visible pixels per line
//  VACTIVE      480   visible lines
//  SCALE_SHIFT  3     log2 of screen pixels per cell edge
//  COLOR_W      3     bits per cell, {r,g,b}
//  BG_COLOR     3'b000  fill value used by clear
//  CLEAR_ON_RST 1     1: run a clear automatically after reset release
// PORTS
//  clk       in   1        pixel clock, 25.175 MHz
//  reset_n   in   1        async assert, active-low
//  x         in   10       horizontal count from timing generator
//  y         in   10       vertical count from timing generator
//  hsync_i   in   1        active-low h sync, same cycle as x/y
//  vsync_i   in   1        active-low v sync, same cycle as x/y
//  blank_b_i in   1        1 = visible pixel, same cycle as x/y
//  wr_valid  in   1        write request
//  wr_ready  out  1        write accepted when wr_valid & wr_ready
//  wr_cx     in   7        cell column, 0..COLS-1
//  wr_cy     in   6        cell row, 0..ROWS-1
//  wr_color  in   COLOR_W  cell value
//  wr_err    out  1        1-cycle pulse: accepted write had an out-of-range coordinate
//  clear_req in   1        pulse: start clear
//  busy      out  1        clear in progress
//  r,g,b     out  1 each   pixel colour out
//  hsync,vsync out 1 each  sync out, aligned with r/g/b
//  blank_b   out  1        aligned blank
// BEHAVIOUR
//  Derived sizes: COLS = HACTIVE>>SCALE_SHIFT; ROWS = VACTIVE>>SCALE_SHIFT; CELLS = COLS*ROWS, 4800 at default.
//  Read address = (y>>S)*COLS + (x>>S). Address width = $clog2(CELLS). Multiply by a constant is allowed.
//  Read pipeline is 2 cycles: stage 1 registers the address; stage 2 is the synchronous RAM read.
//  hsync, vsync and blank_b are delayed by exactly 2 cycles to match the read.
//  r,g,b are forced to 0 when the delayed blank_b is 0.
//  Reset values: r,g,b=0; hsync=vsync=1; blank_b=0; wr_ready=0; wr_err=0; busy=0.
//  Reset does not alter RAM contents. Both pipeline stages are flushed to inactive/blank values.
//  FSM states:
//   RESET_WAIT: entered on reset release; lasts 1 cycle. -> CLEAR if CLEAR_ON_RST, else IDLE.
//   IDLE: wr_ready=1. Write handshake -> RAM written next edge. clear_req -> CLEAR (cnt=0).
//   CLEAR: wr_ready=0, busy=1. Writes BG_COLOR at cnt each cycle. At cnt==CELLS-1 -> IDLE. Takes exactly CELLS cycles.
//  Same cycle wr_valid & wr_ready & clear_req: the write completes, the clear starts next cycle, the write is overwritten.
//  clear_req while in CLEAR is ignored (no restart).
//  Out-of-range write (wr_cx>=COLS or wr_cy>=ROWS): handshake completes, RAM untouched, wr_err pulses the next cycle.
//  Read and write may hit the same address in one cycle: the read returns the old data (read-first).
//  Reset asserted mid-clear: FSM aborts immediately. Partially cleared RAM is acceptable.
//  x/y outside the active area: address is don't-care; the output is blanked anyway.
// CONFIGURATION
//  VGA_CURSOR_EN defined:
//   Extra inputs cur_cx[6:0], cur_cy[5:0].
//   The cell at the cursor is shown bit-inverted while blink=1.
//   blink toggles every 32 frames, counted on vsync_i falling edges. 5-bit frame counter, reset 0; blink reset 0.
//   Overlay is applied in stage 2; latency stays 2.
//  VGA_CURSOR_EN undefined: no cursor ports, no counter, output = RAM data only.
// STRUCTURE
//  Package vga_pkg: HACTIVE/VACTIVE/SCALE_SHIFT defaults; COLS/ROWS/CELLS localparams;
//   typedef color_t = logic [COLOR_W-1:0]; typedef cell_addr_t; enum fb_state_t {RESET_WAIT,IDLE,CLEAR}.
//  Sub-module fb_ram: simple dual-port synchronous RAM, 1 write + 1 read port, 1-cycle read, read-first.
//   Infers BRAM.
// TESTING
//  1 Reset release with CLEAR_ON_RST=1: busy=1 for 4800 cycles, then wr_ready=1. All cells read back 3'b000.
//  2 Write (cx=5, cy=2, color=3'b101), then run a frame:
//    r,g,b=1,0,1 for x=40..47, y=16..23. Output appears 2 cycles after that x/y. All other visible pixels black.
//  3 Sync alignment: hsync/vsync/blank_b outputs equal the inputs delayed 2 cycles over a full 800x525 frame.
//  4 Write (cx=80, cy=0): handshake completes, wr_err=1 one cycle later, no cell changes.
//  5 Same cycle write(0,0,3'b111) + clear_req: busy rises next cycle; after 4800 cycles cell (0,0)=000.
//    A clear_req mid-clear does not extend busy.
//  6 reset_n low for 1 cycle mid-clear: outputs go to reset values immediately.
//    Previously written, uncleared cells keep their data after recovery.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared geometry defaults, cell addressing types and FSM states for the VGA framebuffer
package vga_pkg;

    localparam int DEF_HACTIVE     = 640;
    localparam int DEF_VACTIVE     = 480;
    localparam int DEF_SCALE_SHIFT = 3;
    localparam int DEF_COLOR_W     = 3;

    localparam int COLS        = DEF_HACTIVE >> DEF_SCALE_SHIFT;
    localparam int ROWS        = DEF_VACTIVE >> DEF_SCALE_SHIFT;
    localparam int CELLS       = COLS * ROWS;
    localparam int CELL_ADDR_W = $clog2(CELLS);

    typedef logic [DEF_COLOR_W-1:0] color_t;
    typedef logic [CELL_ADDR_W-1:0] cell_addr_t;

    typedef enum logic [1:0] {
        RESET_WAIT,
        IDLE,
        CLEAR
    } fb_state_t;

endpackage

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - simple dual-port synchronous cell RAM, one write and one read port, read-first
module fb_ram #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4800,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset on storage or read register so the array maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_framebuffer.sv
// rtl/vga_framebuffer.sv - cell framebuffer with 2-cycle pixel pipeline, write port and clear engine
// Optional blinking cursor overlay when VGA_CURSOR_EN is defined.
module vga_framebuffer
    import vga_pkg::*;
#(
    parameter int                 HACTIVE      = DEF_HACTIVE,
    parameter int                 VACTIVE      = DEF_VACTIVE,
    parameter int                 SCALE_SHIFT  = DEF_SCALE_SHIFT,
    parameter int                 COLOR_W      = DEF_COLOR_W,
    parameter logic [COLOR_W-1:0] BG_COLOR     = '0,
    parameter bit                 CLEAR_ON_RST = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               hsync_i,
    input  logic               vsync_i,
    input  logic               blank_b_i,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [6:0]         wr_cx,
    input  logic [5:0]         wr_cy,
    input  logic [COLOR_W-1:0] wr_color,
    output logic               wr_err,
    input  logic               clear_req,
    output logic               busy,
`ifdef VGA_CURSOR_EN
    input  logic [6:0]         cur_cx,
    input  logic [5:0]         cur_cy,
`endif
    output logic               r,
    output logic               g,
    output logic               b,
    output logic               hsync,
    output logic               vsync,
    output logic               blank_b
);

    localparam int N_COLS  = HACTIVE >> SCALE_SHIFT;
    localparam int N_ROWS  = VACTIVE >> SCALE_SHIFT;
    localparam int N_CELLS = N_COLS * N_ROWS;
    localparam int ADDR_W  = $clog2(N_CELLS);

    fb_state_t           state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                wr_err_q, wr_err_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [2:0]          sync1_q, sync2_q;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [COLOR_W-1:0]  ram_wdata;
    logic [COLOR_W-1:0]  ram_rdata;
    logic [COLOR_W-1:0]  pix;
    logic                in_range;
    logic [ADDR_W-1:0]   wr_addr;

    // Stage 1: cell address from the screen position, syncs travel alongside
    always_comb begin
        rd_addr_d = ADDR_W'((32'(y) >> SCALE_SHIFT) * N_COLS + (32'(x) >> SCALE_SHIFT));
    end

    always_comb begin
        in_range = (32'(wr_cx) < 32'(N_COLS)) && (32'(wr_cy) < 32'(N_ROWS));
        wr_addr  = ADDR_W'(32'(wr_cy) * N_COLS + 32'(wr_cx));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = wr_color;
        wr_ready  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            RESET_WAIT: begin
                cnt_d   = '0;
                state_d = CLEAR_ON_RST ? CLEAR : IDLE;
            end
            IDLE: begin
                wr_ready = 1'b1;
                ram_we   = wr_valid && in_range;
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_wdata = BG_COLOR;
                if (cnt_q == ADDR_W'(N_CELLS - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        wr_err_d = wr_valid && wr_ready && !in_range;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RESET_WAIT;
            cnt_q     <= '0;
            wr_err_q  <= 1'b0;
            rd_addr_q <= '0;
            sync1_q   <= 3'b110;
            sync2_q   <= 3'b110;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_err_q  <= wr_err_d;
            rd_addr_q <= rd_addr_d;
            sync1_q   <= {hsync_i, vsync_i, blank_b_i};
            sync2_q   <= sync1_q;
        end
    end

    fb_ram #(
        .DATA_W (COLOR_W),
        .DEPTH  (N_CELLS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_addr_q),
        .rdata_o (ram_rdata)
    );

`ifdef VGA_CURSOR_EN
    logic       hit1_q, hit2_q;
    logic       vs_prev_q;
    logic [4:0] frame_cnt_q;
    logic       blink_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit1_q      <= 1'b0;
            hit2_q      <= 1'b0;
            vs_prev_q   <= 1'b1;
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            hit1_q    <= ((32'(x) >> SCALE_SHIFT) == 32'(cur_cx)) &&
                         ((32'(y) >> SCALE_SHIFT) == 32'(cur_cy));
            hit2_q    <= hit1_q;
            vs_prev_q <= vsync_i;
            // One frame per falling vsync edge; blink flips when the counter wraps
            if (vs_prev_q && !vsync_i) begin
                frame_cnt_q <= frame_cnt_q + 5'd1;
                if (frame_cnt_q == 5'd31) begin
                    blink_q <= ~blink_q;
                end
            end
        end
    end

    assign pix = ram_rdata ^ {COLOR_W{hit2_q & blink_q}};
`else
    assign pix = ram_rdata;
`endif

    assign {r, g, b} = sync2_q[0] ? pix : '0;
    assign hsync     = sync2_q[2];
    assign vsync     = sync2_q[1];
    assign blank_b   = sync2_q[0];
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_vga_framebuffer.sv
// tb/tb_vga_framebuffer.sv - directed self-checking bench for vga_framebuffer
module tb_vga_framebuffer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] x, y;
    logic       hsync_i, vsync_i, blank_b_i;
    logic       wr_valid, wr_ready;
    logic [6:0] wr_cx;
    logic [5:0] wr_cy;
    logic [2:0] wr_color;
    logic       wr_err, clear_req, busy;
    logic       r, g, b, hsync, vsync, blank_b;

    int n_checks = 0;
    int n_fail   = 0;
    string scan_name;

    typedef struct packed {
        logic [9:0] px;
        logic [9:0] py;
        logic [5:0] val;
        logic       chk;
    } pend_t;

    pend_t p1, p2;

    always #5 clk = ~clk;

    vga_framebuffer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .x         (x),
        .y         (y),
        .hsync_i   (hsync_i),
        .vsync_i   (vsync_i),
        .blank_b_i (blank_b_i),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_cx     (wr_cx),
        .wr_cy     (wr_cy),
        .wr_color  (wr_color),
        .wr_err    (wr_err),
        .clear_req (clear_req),
        .busy      (busy),
        .r         (r),
        .g         (g),
        .b         (b),
        .hsync     (hsync),
        .vsync     (vsync),
        .blank_b   (blank_b)
    );

    // 640x480@60 timing: {hsync, vsync, blank_b} for a raster position
    function automatic logic [2:0] tg(input int px, input int py);
        return {!(px >= 656 && px < 752), !(py >= 490 && py < 492), (px < 640 && py < 480)};
    endfunction

    task automatic pipe_reset();
        p1 = '0;
        p2 = '0;
    endtask

    // Drive one pixel; outputs seen now belong to the pixel driven two steps ago
    task automatic pix_step(input logic [9:0] px, input logic [9:0] py, input logic hs,
                            input logic vs, input logic bl, input logic [2:0] exp_rgb, input bit chk);
        @(posedge clk);
        #1;
        if (p2.chk) begin
            n_checks++;
            if ({hsync, vsync, blank_b, r, g, b} !== p2.val) begin
                n_fail++;
                $display("FAIL %s x=%0d y=%0d: {hs,vs,bl,rgb} got %b need %b",
                         scan_name, p2.px, p2.py, {hsync, vsync, blank_b, r, g, b}, p2.val);
            end
        end
        p2 = p1;
        p1 = '{px: px, py: py, val: {hs, vs, bl, exp_rgb}, chk: chk};
        x = px;
        y = py;
        hsync_i = hs;
        vsync_i = vs;
        blank_b_i = bl;
    endtask

    task automatic flush();
        pix_step(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        pix_step(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic read_cell(input int cx, input int cy, input logic [2:0] exp_rgb, input string nm);
        scan_name = nm;
        pipe_reset();
        pix_step(10'(cx * 8), 10'(cy * 8), 1'b1, 1'b1, 1'b1, exp_rgb, 1'b1);
        flush();
    endtask

    task automatic scan_lines(input int y0, input int y1, input int bx0, input int bx1,
                              input int by0, input int by1, input logic [2:0] bc, input string nm);
        logic [2:0] s;
        logic [2:0] e;
        scan_name = nm;
        pipe_reset();
        for (int py = y0; py <= y1; py++) begin
            for (int px = 0; px < 800; px++) begin
                s = tg(px, py);
                e = (s[0] && px >= bx0 && px <= bx1 && py >= by0 && py <= by1) ? bc : 3'b000;
                pix_step(10'(px), 10'(py), s[2], s[1], s[0], e, 1'b1);
            end
        end
        flush();
    endtask

    task automatic wait_ready(input string nm);
        int t;
        t = 0;
        while (wr_ready !== 1'b1 && t < 6000) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s wr_ready timeout: got %b need 1", nm, wr_ready);
        end
    endtask

    task automatic write_cell(input int cx, input int cy, input logic [2:0] col,
                              input logic exp_err, input string nm);
        wait_ready(nm);
        wr_valid = 1'b1;
        wr_cx    = 7'(cx);
        wr_cy    = 6'(cy);
        wr_color = col;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        n_checks++;
        if (wr_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s wr_err: got %b need %b", nm, wr_err, exp_err);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s wr_err not a single pulse: got %b need 0", nm, wr_err);
        end
    endtask

    // Counts consecutive post-edge samples with busy high; optional clear_req pulse mid-way
    task automatic measure_busy(input int pulse_at, output int n);
        n = 0;
        while (busy === 1'b1 && n < 6000) begin
            n++;
            clear_req = (n == pulse_at);
            @(posedge clk);
            #1;
        end
        clear_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        n_checks++;
        if ({r, g, b, hsync, vsync, blank_b, wr_ready, wr_err, busy} !== 9'b000_110_000) begin
            n_fail++;
            $display("FAIL %s {rgb,hs,vs,bl,rdy,err,busy} got %b need 000110000", nm,
                     {r, g, b, hsync, vsync, blank_b, wr_ready, wr_err, busy});
        end
    endtask

    task automatic test_reset();
        int n;
        reset_n   = 1'b0;
        x         = 10'd0;
        y         = 10'd0;
        hsync_i   = 1'b0;
        vsync_i   = 1'b0;
        blank_b_i = 1'b1;
        wr_valid  = 1'b0;
        wr_cx     = '0;
        wr_cy     = '0;
        wr_color  = '0;
        clear_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        reset_n = 1'b1;
        hsync_i = 1'b1;
        vsync_i = 1'b1;
        blank_b_i = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait busy/ready: got %b%b need 00", busy, wr_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_on_rst start busy: got %b need 1", busy);
        end
        measure_busy(0, n);
        n_checks++;
        if (n != 4800) begin
            n_fail++;
            $display("FAIL clear_on_rst busy cycles: got %0d need 4800", n);
        end
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after clear wr_ready: got %b need 1", wr_ready);
        end
        scan_name = "readback_all_cleared";
        pipe_reset();
        for (int cy = 0; cy < 60; cy++) begin
            for (int cx = 0; cx < 80; cx++) begin
                pix_step(10'(cx * 8), 10'(cy * 8), 1'b1, 1'b1, 1'b1, 3'b000, 1'b1);
            end
        end
        flush();
    endtask

    task automatic test_write_frame();
        write_cell(5, 2, 3'b101, 1'b0, "write_5_2");
        scan_lines(14, 25, 40, 47, 16, 23, 3'b101, "frame_cell_5_2");
    endtask

    task automatic test_sync_align();
        scan_lines(476, 495, 0, -1, 0, -1, 3'b000, "sync_align");
        scan_lines(0, 1, 0, -1, 0, -1, 3'b000, "sync_align_top");
    endtask

    task automatic test_out_of_range();
        write_cell(80, 0, 3'b111, 1'b1, "oob_cx80");
        write_cell(79, 60, 3'b111, 1'b1, "oob_cy60");
        read_cell(0, 1, 3'b000, "oob_alias_cell_0_1");
        read_cell(5, 2, 3'b101, "oob_keep_5_2");
        read_cell(79, 59, 3'b000, "oob_keep_79_59");
    endtask

    task automatic test_write_clear_same_cycle();
        int n;
        wait_ready("wr_clr_ready");
        wr_valid  = 1'b1;
        wr_cx     = 7'd0;
        wr_cy     = 6'd0;
        wr_color  = 3'b111;
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_clr busy/ready: got %b%b need 10", busy, wr_ready);
        end
        measure_busy(100, n);
        n_checks++;
        if (n != 4800) begin
            n_fail++;
            $display("FAIL wr_clr busy cycles with mid-clear req: got %0d need 4800", n);
        end
        read_cell(0, 0, 3'b000, "wr_clr_cell_0_0");
        read_cell(5, 2, 3'b000, "wr_clr_cell_5_2");
    endtask

    task automatic test_reset_mid_clear();
        int n;
        write_cell(79, 59, 3'b110, 1'b0, "mid_write_79_59");
        wait_ready("mid_ready");
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        scan_name = "pre_reset_output";
        pipe_reset();
        pix_step(10'd632, 10'd472, 1'b0, 1'b0, 1'b1, 3'b110, 1'b1);
        pix_step(10'd632, 10'd472, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0);
        pix_step(10'd632, 10'd472, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_clear busy before reset: got %b need 1", busy);
        end
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_clear");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        read_cell(79, 59, 3'b110, "uncleared_79_59_kept");
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL post-reset clear busy: got %b need 1", busy);
        end
        measure_busy(0, n);
        n_checks++;
        if (n < 4790 || n > 4800) begin
            n_fail++;
            $display("FAIL post-reset clear length: got %0d need 4790..4800", n);
        end
        read_cell(79, 59, 3'b000, "post_reset_clear_79_59");
    endtask

    initial begin
        test_reset();
        test_write_frame();
        test_sync_align();
        test_out_of_range();
        test_write_clear_same_cycle();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
